// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one serial lane among NUM_REQ word producers.
// Each grant emits a frame: start pulse, winner ID (LSB first), captured data word (LSB first).
module serial_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     serial_out,
  output logic                     start,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int MAXW  = (WIDTH > ID_W) ? WIDTH : ID_W;
  localparam int CNT_W = $clog2(MAXW + 1);

  typedef enum logic [1:0] {IDLE, START_PULSE, SEND_ID, SEND_DATA} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_nxt;
  logic [WIDTH-1:0]                shadow_q, shadow_d, shadow_sh;
  logic [ID_W-1:0]                 gid_q, gid_d, gid_sh;
  logic [ID_W-1:0]                 last_q, last_d;
  logic [NUM_REQ-1:0]              ready_q, ready_d;
  logic                            ser_q, ser_d;
  logic                            start_q, start_d;
  logic                            fdone_q, fdone_d;
  logic [ID_W-1:0]                 win_idx;
  logic                            win_found;
  logic [NUM_REQ-1:0][WIDTH-1:0]   words;

  assign words = req_data;

  // Scan starts just past the last winner and wraps, so the previous winner has lowest priority.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[ID_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
  end

  assign cnt_nxt   = cnt_q + 1'b1;
  assign shadow_sh = shadow_q >> cnt_nxt;
  assign gid_sh    = gid_q >> cnt_nxt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    gid_d    = gid_q;
    last_d   = last_q;
    ready_d  = '0;
    ser_d    = 1'b0;
    start_d  = 1'b0;
    fdone_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          shadow_d         = words[win_idx];
          gid_d            = win_idx;
          last_d           = win_idx;
          ready_d[win_idx] = 1'b1;
          start_d          = 1'b1;
          state_d          = START_PULSE;
        end
      end
      START_PULSE: begin
        ser_d   = gid_q[0];
        cnt_d   = '0;
        state_d = SEND_ID;
      end
      SEND_ID: begin
        if (cnt_q == CNT_W'(ID_W - 1)) begin
          ser_d   = shadow_q[0];
          cnt_d   = '0;
          state_d = SEND_DATA;
        end else begin
          cnt_d = cnt_nxt;
          ser_d = gid_sh[0];
        end
      end
      SEND_DATA: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          fdone_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_nxt;
          ser_d = shadow_sh[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      gid_q    <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
      ready_q  <= '0;
      ser_q    <= 1'b0;
      start_q  <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      ser_q    <= ser_d;
      start_q  <= start_d;
      fdone_q  <= fdone_d;
    end
  end

  assign req_ready  = ready_q;
  assign serial_out = ser_q;
  assign start      = start_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fdone_q;

endmodule
